// File: rtl/pi_rx_pkg.sv
// pi_rx_pkg: shared definitions for the framed GPIO receiver.
//   rx_state_t   - receiver FSM state encoding
//   SOF_DEFAULT  - default start-of-frame code
//   HDR_LSB/MSB  - bit range of a beat that carries header/checksum fields
package pi_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BANK,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM
  } rx_state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  localparam int HDR_LSB = 0;
  localparam int HDR_MSB = 7;

endpackage

// File: rtl/pi_frame_rx_ram.sv
// pi_bank_ram: NUM_BANKS x DEPTH word store for received payloads.
//   pi_clk            clock
//   rst               synchronous reset (clears the read register only)
//   we/wr_bank/wr_addr/wr_data   single write port
//   rd_bank/rd_addr   read address, sampled on posedge
//   rd_data           registered read data, old value on same-address write
module pi_bank_ram #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int NUM_BANKS = 4
) (
  input  logic                         pi_clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [$clog2(NUM_BANKS)-1:0] wr_bank,
  input  logic [$clog2(DEPTH)-1:0]     wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [$clog2(NUM_BANKS)-1:0] rd_bank,
  input  logic [$clog2(DEPTH)-1:0]     rd_addr,
  output logic [DATA_W-1:0]            rd_data
);

  localparam int MW = $clog2(NUM_BANKS * DEPTH);

  logic [DATA_W-1:0] mem [NUM_BANKS*DEPTH];
  logic [MW-1:0]     wr_idx;
  logic [MW-1:0]     rd_idx;

  assign wr_idx = MW'(wr_bank) * MW'(DEPTH) + MW'(wr_addr);
  assign rd_idx = MW'(rd_bank) * MW'(DEPTH) + MW'(rd_addr);

  // Memory array is left without reset so it maps onto block RAM.
  always_ff @(posedge pi_clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  // Non-blocking read of the array gives read-before-write on collisions.
  always_ff @(posedge pi_clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/pi_frame_rx.sv
// pi_frame_rx: framed receiver from the Pi parallel GPIO bus into banked memory.
// Frame: SOF, bank id, length n, n payload words, XOR checksum (n+4 beats).
//   pi_clk, rst                 clock, synchronous active-high reset
//   gpio_data/gpio_valid        beat from the Pi, accepted when write_enable high
//   write_enable                receive gate
//   rd_bank/rd_addr/rd_data     registered read port into the banks
//   bank_valid                  per-bank "complete, checksum good" flags
//   busy                        high whenever a frame is in progress
//   frame_ok/frame_err          one-cycle commit/abort pulses
//   led                         {err_sticky, bank_valid[rd_bank], rd_data[3:0]}
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | hunting for SOF, other beats dropped silently
// ST_BANK    | next beat is the bank id
// ST_LEN     | next beat is the payload length
// ST_PAYLOAD | writing payload words into the selected bank
// ST_CSUM    | next beat is compared against the running XOR
module pi_frame_rx
  import pi_rx_pkg::*;
#(
  parameter int         DATA_W    = 8,
  parameter int         DEPTH     = 16,
  parameter int         NUM_BANKS = 4,
  parameter logic [7:0] SOF       = SOF_DEFAULT,
  parameter int         TIMEOUT   = 1024
) (
  input  logic                         pi_clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            gpio_data,
  input  logic                         gpio_valid,
  input  logic                         write_enable,
  input  logic [$clog2(NUM_BANKS)-1:0] rd_bank,
  input  logic [$clog2(DEPTH)-1:0]     rd_addr,
  output logic [DATA_W-1:0]            rd_data,
  output logic [NUM_BANKS-1:0]         bank_valid,
  output logic                         busy,
  output logic                         frame_ok,
  output logic                         frame_err,
  output logic [5:0]                   led
);

  localparam int BW = $clog2(NUM_BANKS);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  rx_state_t     state;
  logic [BW-1:0] bank_q;
  logic [7:0]    len_q;
  logic [7:0]    cnt_q;
  logic [7:0]    csum_q;
  logic [TW-1:0] idle_tmr;
  logic          err_sticky;

  logic          beat;
  logic [7:0]    hdr;
  logic          mem_we;

  assign beat   = gpio_valid && write_enable;
  assign hdr    = gpio_data[HDR_MSB:HDR_LSB];
  assign mem_we = beat && (state == ST_PAYLOAD) && !rst;
  assign busy   = (state != ST_IDLE);
  assign led    = {err_sticky, bank_valid[rd_bank], rd_data[3:0]};

  always_ff @(posedge pi_clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bank_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      csum_q     <= '0;
      idle_tmr   <= '0;
      bank_valid <= '0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      // Remaining idle cycles before abort; reloaded by every accepted beat,
      // so it runs on regardless of write_enable.
      if (state != ST_IDLE && !beat) begin
        if (idle_tmr == '0) begin
          state      <= ST_IDLE;
          frame_err  <= 1'b1;
          err_sticky <= 1'b1;
        end else begin
          idle_tmr <= idle_tmr - 1'b1;
        end
      end

      if (beat) begin
        idle_tmr <= TMR_LOAD;
        unique case (state)
          ST_IDLE: begin
            if (hdr == SOF) state <= ST_BANK;
          end
          ST_BANK: begin
            if ({24'd0, hdr} >= 32'(NUM_BANKS)) begin
              state      <= ST_IDLE;
              frame_err  <= 1'b1;
              err_sticky <= 1'b1;
            end else begin
              bank_q <= hdr[BW-1:0];
              csum_q <= hdr;
              state  <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (hdr == 8'd0 || {24'd0, hdr} > 32'(DEPTH)) begin
              state      <= ST_IDLE;
              frame_err  <= 1'b1;
              err_sticky <= 1'b1;
            end else begin
              len_q              <= hdr;
              csum_q             <= csum_q ^ hdr;
              cnt_q              <= '0;
              bank_valid[bank_q] <= 1'b0;
              state              <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            csum_q <= csum_q ^ hdr;
            cnt_q  <= cnt_q + 8'd1;
            if (cnt_q == len_q - 8'd1) state <= ST_CSUM;
          end
          ST_CSUM: begin
            if (hdr == csum_q) begin
              bank_valid[bank_q] <= 1'b1;
              frame_ok           <= 1'b1;
              err_sticky         <= 1'b0;
            end else begin
              frame_err  <= 1'b1;
              err_sticky <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  pi_bank_ram #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .NUM_BANKS (NUM_BANKS)
  ) u_ram (
    .pi_clk  (pi_clk),
    .rst     (rst),
    .we      (mem_we),
    .wr_bank (bank_q),
    .wr_addr (cnt_q[AW-1:0]),
    .wr_data (gpio_data),
    .rd_bank (rd_bank),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule
